// File: rtl/demux_scan_ctrl_pkg.sv
// demux_scan_ctrl_pkg
//   Shared definitions for the demux scan controller:
//   - FSM state encodings (IDLE / SHOW / BLANK)
//   - default dwell and blanking lengths
//   - constant helper functions used to size the dwell counter
package demux_scan_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHOW  = 2'd1;
  localparam logic [1:0] ST_BLANK = 2'd2;

  localparam int DEF_PRESCALE  = 50000;
  localparam int DEF_BLANK_CYC = 1000;

  // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(5) = 3.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/demux_next_sel.sv
// demux_next_sel
//   Combinational rotate-priority finder for the scan controller.
//   Ports:
//     mask      in   per-output enable bits
//     cur_sel   in   currently selected output
//     next_sel  out  lowest set mask bit strictly above cur_sel, else the
//                    lowest set mask bit (wrap)
//     wrap      out  1 when no set bit lies above cur_sel and mask != 0
//     none      out  1 when mask is all zero (next_sel is then 0)
module demux_next_sel #(
  parameter int N_OUT = 4,
  parameter int N_SEL = 2
) (
  input  logic [N_OUT-1:0] mask,
  input  logic [N_SEL-1:0] cur_sel,
  output logic [N_SEL-1:0] next_sel,
  output logic             wrap,
  output logic             none
);

  logic [N_SEL-1:0] above_s;
  logic [N_SEL-1:0] low_s;
  logic             found_s;

  // Scan from the top down so the last hit is the lowest qualifying bit.
  always_comb begin
    above_s = {N_SEL{1'b0}};
    low_s   = {N_SEL{1'b0}};
    found_s = 1'b0;
    for (int i = N_OUT - 1; i >= 0; i--) begin
      low_s   = mask[i] ? N_SEL'(i) : low_s;
      above_s = (mask[i] && (i > int'(cur_sel))) ? N_SEL'(i) : above_s;
      found_s = found_s | (mask[i] && (i > int'(cur_sel)));
    end
    none     = ~(|mask);
    next_sel = found_s ? above_s : low_s;
    wrap     = ~found_s & ~none;
  end

endmodule

// File: rtl/demux_scan_ctrl.sv
// demux_scan_ctrl
//   Time-multiplexing scan controller for a 1-to-N_OUT demux. Each enabled
//   output is driven for PRESCALE cycles, followed by BLANK_CYC cycles of
//   blanking (none when BLANK_CYC = 0), then the next enabled output.
//   Ports:
//     clk         in   system clock, rising edge
//     reset_n     in   asynchronous active-low reset
//     en          in   scan enable (level)
//     mask        in   per-output enable, bit i includes output i
//     sel         out  demux select (registered)
//     demux_in    out  demux data input, 1 drives output sel (registered)
//     digit_tick  out  pulse in the first SHOW cycle of every digit
//     frame_done  out  pulse in the first SHOW cycle of each frame after
//                      the first one
//     onehot_out  out  demux_in << sel, present only with SCAN_ONEHOT_EN
//   Optional feature macro: SCAN_ONEHOT_EN
module demux_scan_ctrl
  import demux_scan_ctrl_pkg::*;
#(
  parameter int N_OUT     = 4,
  parameter int N_SEL     = 2,
  parameter int PRESCALE  = DEF_PRESCALE,
  parameter int BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [N_OUT-1:0] mask,
  output logic [N_SEL-1:0] sel,
  output logic             demux_in,
  output logic             digit_tick,
  output logic             frame_done
`ifdef SCAN_ONEHOT_EN
  ,
  output logic [N_OUT-1:0] onehot_out
`endif
);

  localparam int CNT_W = clog2(max3(PRESCALE, BLANK_CYC, 2));
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam bit               HAS_BLANK  = (BLANK_CYC > 0);

  logic [1:0]       state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [N_SEL-1:0] sel_r, sel_nxt_s;
  logic             demux_in_r, demux_in_nxt_s;
  logic             digit_tick_r, digit_tick_nxt_s;
  logic             frame_done_r, frame_done_nxt_s;

  logic [N_SEL-1:0] low_sel_s;
  logic [N_SEL-1:0] next_sel_s;
  logic             wrap_s;
  logic             none_s;
  logic             adv_s;

  demux_next_sel #(
    .N_OUT (N_OUT),
    .N_SEL (N_SEL)
  ) u_next_sel (
    .mask     (mask),
    .cur_sel  (sel_r),
    .next_sel (next_sel_s),
    .wrap     (wrap_s),
    .none     (none_s)
  );

  // Lowest enabled output, used when a scan starts from IDLE.
  always_comb begin
    low_sel_s = {N_SEL{1'b0}};
    for (int i = N_OUT - 1; i >= 0; i--) begin
      low_sel_s = mask[i] ? N_SEL'(i) : low_sel_s;
    end
  end

  // Advance point: end of the dwell when blanking is off, else end of blank.
  // This is the only place mask is sampled once a scan is running.
  assign adv_s = en & (((state_r == ST_SHOW) & (cnt_r == SHOW_LAST) & ~HAS_BLANK) |
                       ((state_r == ST_BLANK) & (cnt_r == BLANK_LAST)));

  // Next-state and next-output computation for the scan FSM.
  always_comb begin
    state_nxt_s      = state_r;
    cnt_nxt_s        = cnt_r;
    sel_nxt_s        = sel_r;
    demux_in_nxt_s   = demux_in_r;
    digit_tick_nxt_s = 1'b0;
    frame_done_nxt_s = 1'b0;
    if (!en) begin
      state_nxt_s    = ST_IDLE;
      cnt_nxt_s      = CNT_ZERO;
      demux_in_nxt_s = 1'b0;
    end else if (adv_s) begin
      cnt_nxt_s = CNT_ZERO;
      if (none_s) begin
        state_nxt_s    = ST_IDLE;
        demux_in_nxt_s = 1'b0;
      end else begin
        state_nxt_s      = ST_SHOW;
        sel_nxt_s        = next_sel_s;
        demux_in_nxt_s   = 1'b1;
        digit_tick_nxt_s = 1'b1;
        frame_done_nxt_s = wrap_s;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_nxt_s      = CNT_ZERO;
          demux_in_nxt_s = 1'b0;
          if (|mask) begin
            state_nxt_s      = ST_SHOW;
            sel_nxt_s        = low_sel_s;
            demux_in_nxt_s   = 1'b1;
            digit_tick_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_SHOW: begin
          // The last count only reaches here when blanking is enabled.
          if (cnt_r == SHOW_LAST) begin
            state_nxt_s    = ST_BLANK;
            cnt_nxt_s      = CNT_ZERO;
            demux_in_nxt_s = 1'b0;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        ST_BLANK: begin
          cnt_nxt_s      = cnt_r + CNT_ONE;
          demux_in_nxt_s = 1'b0;
        end
        default: begin
          state_nxt_s    = ST_IDLE;
          cnt_nxt_s      = CNT_ZERO;
          demux_in_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // Scan state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= CNT_ZERO;
      sel_r        <= {N_SEL{1'b0}};
      demux_in_r   <= 1'b0;
      digit_tick_r <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      sel_r        <= sel_nxt_s;
      demux_in_r   <= demux_in_nxt_s;
      digit_tick_r <= digit_tick_nxt_s;
      frame_done_r <= frame_done_nxt_s;
    end
  end

  assign sel        = sel_r;
  assign demux_in   = demux_in_r;
  assign digit_tick = digit_tick_r;
  assign frame_done = frame_done_r;

`ifdef SCAN_ONEHOT_EN
  logic [N_OUT-1:0] onehot_nxt_s;
  logic [N_OUT-1:0] onehot_r;

  // Decoded select, built from the same next values as sel/demux_in.
  always_comb begin
    onehot_nxt_s = {N_OUT{1'b0}};
    for (int i = 0; i < N_OUT; i++) begin
      onehot_nxt_s[i] = demux_in_nxt_s & (sel_nxt_s == N_SEL'(i));
    end
  end

  // Registered one-hot output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      onehot_r <= {N_OUT{1'b0}};
    end else begin
      onehot_r <= onehot_nxt_s;
    end
  end

  assign onehot_out = onehot_r;
`endif

endmodule
